// File: rtl/wb_src_mux_n.sv
// rtl/wb_src_mux_n.sv - registered N:1 write-back source selector with valid/ready handshakes
// Grant is combinational (explicit sel, fixed priority or round-robin); one-entry output register.
module wb_src_mux_n #(
  parameter int WIDTH    = 8,
  parameter int NUM_SRC  = 2,
  parameter int ARB_MODE = 0,
  localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SEL_W-1:0]           out_src
);

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_src_q, out_src_d;
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic               load_en, gnt_vld, xfer;
  logic [SEL_W-1:0]   gnt_idx;
  int                 rr_idx;

  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    case (ARB_MODE)
      0: begin
        // Comparing against each legal index keeps an out-of-range sel from granting.
        for (int i = 0; i < NUM_SRC; i++) begin
          if (sel == SEL_W'(i) && src_valid[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = SEL_W'(i);
          end
        end
      end
      1: begin
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          if (src_valid[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = SEL_W'(i);
          end
        end
      end
      default: begin
        // Scan from farthest to nearest so the source closest to rr_q wins.
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
          rr_idx = int'(rr_q) + j;
          if (rr_idx >= NUM_SRC) rr_idx = rr_idx - NUM_SRC;
          if (src_valid[rr_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = SEL_W'(rr_idx);
          end
        end
      end
    endcase
  end

  assign xfer      = rst_n && load_en && gnt_vld;
  assign src_ready = xfer ? (NUM_SRC'(1) << gnt_idx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_d        = rr_q;
    if (load_en) out_valid_d = gnt_vld;
    if (load_en && gnt_vld) begin
      out_data_d = src_data[gnt_idx*WIDTH +: WIDTH];
      out_src_d  = gnt_idx;
      if (ARB_MODE == 2)
        rr_d = (gnt_idx == SEL_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_q        <= rr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
